control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-002 The block SHALL have port clk, input, 1 bit, the system clock.
REQ-003 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit, a one-cycle pulse that leaves the HALT state.
REQ-005 The block SHALL have port pc, output, 8 bits, the program ROM address.
REQ-006 The block SHALL have port instr, input, 8 bits, the ROM data; instr in cycle N SHALL equal mem[pc of cycle N-1].
REQ-007 The block SHALL have port aluOpe, output, 3 bits, the ALU operation, driven with the package codes moveCode, incrementCode, addCode, subCode, andCode, orCode, xorCode and notCode.
REQ-008 The block SHALL have port data, output, 8 bits, the ALU immediate operand.
REQ-009 The block SHALL have port acc_we, output, 1 bit, the accumulator write enable that commits the ALU output.
REQ-010 The block SHALL have port acc_zero, input, 1 bit, high when the accumulator equals 0x00.
REQ-011 The block SHALL have port halted, output, 1 bit, high while in the HALT state.
REQ-012 The block SHALL have port illegal, output, 1 bit, a sticky flag set by an undefined opcode.

Function
REQ-013 Opcode SHALL be instr[7:4]; instr[3:0] SHALL be ignored.
REQ-014 The opcode set SHALL be:
- 0x0 NOP;
- 0x1 LDI (moveCode);
- 0x2 ADDI (addCode);
- 0x3 SUBI (subCode);
- 0x4 ANDI (andCode);
- 0x5 ORI (orCode);
- 0x6 XORI (xorCode);
- 0x7 INC (incrementCode);
- 0x8 NOT (notCode);
- 0x9 JMP;
- 0xA JZ;
- 0xF HALT;
- 0xB-0xE illegal.
REQ-015 Two-byte instructions SHALL be 0x1-0x6, 0x9 and 0xA, with the second byte at pc+1; all other instructions SHALL be one-byte.
REQ-016 The FSM states SHALL be FETCH, DECODE, OPWAIT, EXECUTE and HALT.
REQ-017 FETCH SHALL go to DECODE unconditionally.
REQ-018 In DECODE the block SHALL:
- latch instr into the internal instruction register ir;
- set pc <= pc+1;
- go to OPWAIT for two-byte opcodes;
- go to HALT for 0xF;
- go to EXECUTE otherwise.
REQ-019 OPWAIT SHALL go to EXECUTE unconditionally, with pc unchanged.
REQ-020 EXECUTE SHALL go to FETCH.
REQ-021 In EXECUTE of a two-byte instruction, the operand SHALL be instr, valid that cycle and used combinationally.
REQ-022 In EXECUTE of a two-byte ALU operation, pc SHALL be set to pc+1.
REQ-023 Per-instruction latency SHALL be 3 cycles for one-byte instructions and 4 cycles for two-byte instructions.
REQ-024 acc_we SHALL be 1 only in the EXECUTE cycle of opcodes 0x1-0x8, and 0 in all other cycles.
REQ-025 aluOpe SHALL follow ir per REQ-014, and SHALL be moveCode for non-ALU opcodes.
REQ-026 data SHALL be instr in EXECUTE of opcodes 0x1-0x6, and 0x00 otherwise.
REQ-027 JMP SHALL set pc <= instr in EXECUTE.
REQ-028 JZ SHALL sample acc_zero in EXECUTE: pc <= instr if it is 1, else pc <= pc+1.
REQ-029 NOP and illegal opcodes SHALL execute as a one-byte no-op.
REQ-030 An illegal opcode SHALL set illegal=1 at the end of DECODE; illegal SHALL clear only on reset.
REQ-031 In HALT, pc SHALL hold its value and halted SHALL be 1.
REQ-032 A start pulse in HALT SHALL move the FSM to FETCH at the current pc.
REQ-033 start SHALL be ignored in all states other than HALT.
REQ-034 pc arithmetic SHALL be modulo 256 (0xFF+1 = 0x00), including the operand fetch across the wrap.
REQ-035 A HALT opcode SHALL leave pc at the address after HALT, so that start resumes with the next instruction.

Reset
REQ-036 With rst=1 at a clock edge, the block SHALL set:
- state = HALT;
- pc = 0x00;
- ir = 0x00;
- illegal = 0;
- acc_we = 0;
- halted = 1;
- aluOpe = moveCode;
- data = 0x00.
REQ-037 rst SHALL take priority over start and over any in-progress instruction, in any state; no acc_we pulse SHALL escape on the edge where reset is applied.

Verification
REQ-038 The bench SHALL apply reset, then start, with ROM[0..1] = 0x10, 0x05, and SHALL check:
- FETCH, DECODE, OPWAIT, EXECUTE on cycles 1-4;
- on cycle 4, acc_we=1, aluOpe=moveCode, data=0x05;
- pc=0x02 on cycle 5.
REQ-039 The bench SHALL place ROM[0xFF] = 0x70 (INC) and SHALL check:
- a 3-cycle execution;
- acc_we=1 with aluOpe=incrementCode and data=0x00;
- pc wraps to 0x00.
REQ-040 The bench SHALL run JZ 0x40 at pc=0x10 and SHALL check:
- with acc_zero=1 in EXECUTE, the next FETCH is at pc=0x40;
- with acc_zero=0, the next FETCH is at pc=0x12.
REQ-041 The bench SHALL run opcode 0xC0 at pc=0x05 and SHALL check: no acc_we, illegal=1 from the following cycle, and next pc=0x06.
REQ-042 The bench SHALL run 0xF0 at pc=0x07 and SHALL check:
- halted=1 from the cycle after DECODE, with pc frozen at 0x08 for 10 cycles;
- a start pulse resumes with FETCH at 0x08.
REQ-043 The bench SHALL assert rst during the OPWAIT of ADDI and SHALL check:
- next cycle state is HALT with pc=0x00;
- acc_we never pulses;
- illegal=0.

Source files
------------

// File: rtl/control_unit.sv
// Multi-cycle control unit for an 8-bit accumulator machine: fetches from a
// synchronous-read ROM, decodes one/two-byte instructions and drives the ALU.
package control_unit_pkg;
   localparam logic [2:0] moveCode      = 3'd0;
   localparam logic [2:0] incrementCode = 3'd1;
   localparam logic [2:0] addCode       = 3'd2;
   localparam logic [2:0] subCode       = 3'd3;
   localparam logic [2:0] andCode       = 3'd4;
   localparam logic [2:0] orCode        = 3'd5;
   localparam logic [2:0] xorCode       = 3'd6;
   localparam logic [2:0] notCode       = 3'd7;
endpackage

module control_unit
   import control_unit_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic [7:0] pc,
   input  logic [7:0] instr,
   output logic [2:0] aluOpe,
   output logic [7:0] data,
   output logic       acc_we,
   input  logic       acc_zero,
   output logic       halted,
   output logic       illegal
);

   localparam logic [2:0] FETCH   = 3'd0;
   localparam logic [2:0] DECODE  = 3'd1;
   localparam logic [2:0] OPWAIT  = 3'd2;
   localparam logic [2:0] EXECUTE = 3'd3;
   localparam logic [2:0] HALT    = 3'd4;

   function automatic logic is_two_byte(input logic [3:0] op);
      return ((op >= 4'h1) && (op <= 4'h6)) || (op == 4'h9) || (op == 4'hA);
   endfunction

   function automatic logic is_alu(input logic [3:0] op);
      return (op >= 4'h1) && (op <= 4'h8);
   endfunction

   function automatic logic is_illegal(input logic [3:0] op);
      return (op >= 4'hB) && (op <= 4'hE);
   endfunction

   function automatic logic [2:0] alu_code(input logic [3:0] op);
      logic [2:0] code;
      case (op)
         4'h1:    code = moveCode;
         4'h2:    code = addCode;
         4'h3:    code = subCode;
         4'h4:    code = andCode;
         4'h5:    code = orCode;
         4'h6:    code = xorCode;
         4'h7:    code = incrementCode;
         4'h8:    code = notCode;
         default: code = moveCode;
      endcase
      return code;
   endfunction

   logic [2:0] state_r, state_next_s;
   logic [7:0] pc_r, pc_next_s;
   logic [7:0] ir_r;
   logic       illegal_r;
   logic [3:0] ir_op_s;
   logic [3:0] instr_op_s;
   logic       execute_s;
   logic       unused_ir_s;

   assign ir_op_s     = ir_r[7:4];
   assign instr_op_s  = instr[7:4];
   assign execute_s   = (state_r == EXECUTE);
   assign unused_ir_s = ^ir_r[3:0];

   // Next-state and next-pc; in EXECUTE of a two-byte op, instr is the operand
   always_comb begin
      state_next_s = state_r;
      pc_next_s    = pc_r;
      case (state_r)
         FETCH: state_next_s = DECODE;
         DECODE: begin
            pc_next_s = pc_r + 8'd1;
            if (is_two_byte(instr_op_s)) begin
               state_next_s = OPWAIT;
            end else if (instr_op_s == 4'hF) begin
               state_next_s = HALT;
            end else begin
               state_next_s = EXECUTE;
            end
         end
         OPWAIT: state_next_s = EXECUTE;
         EXECUTE: begin
            state_next_s = FETCH;
            if (ir_op_s == 4'h9) begin
               pc_next_s = instr;
            end else if (ir_op_s == 4'hA) begin
               pc_next_s = acc_zero ? instr : pc_r + 8'd1;
            end else if (is_two_byte(ir_op_s)) begin
               pc_next_s = pc_r + 8'd1;
            end else begin
               pc_next_s = pc_r;
            end
         end
         HALT: begin
            if (start) begin
               state_next_s = FETCH;
            end else begin
               state_next_s = HALT;
            end
         end
         default: state_next_s = HALT;
      endcase
   end

   // State, pc, instruction register and sticky illegal flag
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= HALT;
         pc_r      <= 8'h00;
         ir_r      <= 8'h00;
         illegal_r <= 1'b0;
      end else begin
         state_r <= state_next_s;
         pc_r    <= pc_next_s;
         if (state_r == DECODE) begin
            ir_r <= instr;
         end
         if ((state_r == DECODE) && is_illegal(instr_op_s)) begin
            illegal_r <= 1'b1;
         end
      end
   end

   // Reset gates acc_we so a commit cannot slip through on the reset edge
   always_comb begin
      acc_we = execute_s && is_alu(ir_op_s) && !rst;
      aluOpe = alu_code(ir_op_s);
      if (execute_s && (ir_op_s >= 4'h1) && (ir_op_s <= 4'h6)) begin
         data = instr;
      end else begin
         data = 8'h00;
      end
   end

   assign pc      = pc_r;
   assign halted  = (state_r == HALT);
   assign illegal = illegal_r;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: a bench-side synchronous ROM runs a short
// program covering LDI, JMP, JZ, illegal, NOP, HALT/resume, pc wrap and reset.
module tb_control_unit;
   import control_unit_pkg::*;

   localparam logic [2:0] S_FETCH   = 3'd0;
   localparam logic [2:0] S_DECODE  = 3'd1;
   localparam logic [2:0] S_OPWAIT  = 3'd2;
   localparam logic [2:0] S_EXECUTE = 3'd3;
   localparam logic [2:0] S_HALT    = 3'd4;

   logic       clk = 1'b0;
   logic       rst, start, acc_zero;
   logic [7:0] pc, instr, data;
   logic [2:0] aluOpe;
   logic       acc_we, halted, illegal;
   logic [7:0] mem [256];
   int         vectors = 0;
   int         miscompares = 0;
   int         we_seen = 0;
   logic       mon_en = 1'b0;

   control_unit dut (
      .clk(clk), .rst(rst), .start(start), .pc(pc), .instr(instr),
      .aluOpe(aluOpe), .data(data), .acc_we(acc_we), .acc_zero(acc_zero),
      .halted(halted), .illegal(illegal)
   );

   always #5 clk = ~clk;

   always @(posedge clk) instr <= mem[pc];

   always @(posedge clk) if (mon_en && acc_we) we_seen++;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; acc_zero = 1'b0;
      tick(2);
      if (dut.state_r !== S_HALT) begin miscompares++; $display("FAIL rst_state got %0d want %0d", dut.state_r, S_HALT); end vectors++;
      if (pc !== 8'h00) begin miscompares++; $display("FAIL rst_pc got %h want 00", pc); end vectors++;
      if (dut.ir_r !== 8'h00) begin miscompares++; $display("FAIL rst_ir got %h want 00", dut.ir_r); end vectors++;
      if ({halted, illegal, acc_we} !== 3'b100) begin miscompares++; $display("FAIL rst_flags got %b want 100", {halted, illegal, acc_we}); end vectors++;
      if (aluOpe !== moveCode || data !== 8'h00) begin miscompares++; $display("FAIL rst_alu got %0d/%h want %0d/00", aluOpe, data, moveCode); end vectors++;
      rst = 1'b0;
      tick(3);
      if (dut.state_r !== S_HALT || pc !== 8'h00) begin miscompares++; $display("FAIL idle_halt got %0d/%h want %0d/00", dut.state_r, pc, S_HALT); end vectors++;
   endtask

   task automatic test_ldi;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      if (dut.state_r !== S_FETCH || pc !== 8'h00) begin miscompares++; $display("FAIL ldi_c1 got %0d/%h want %0d/00", dut.state_r, pc, S_FETCH); end vectors++;
      tick(1);
      if (dut.state_r !== S_DECODE) begin miscompares++; $display("FAIL ldi_c2 got %0d want %0d", dut.state_r, S_DECODE); end vectors++;
      tick(1);
      if (dut.state_r !== S_OPWAIT || pc !== 8'h01 || acc_we !== 1'b0) begin miscompares++; $display("FAIL ldi_c3 got %0d/%h/%b want %0d/01/0", dut.state_r, pc, acc_we, S_OPWAIT); end vectors++;
      tick(1);
      if (dut.state_r !== S_EXECUTE) begin miscompares++; $display("FAIL ldi_c4_state got %0d want %0d", dut.state_r, S_EXECUTE); end vectors++;
      if (acc_we !== 1'b1 || aluOpe !== moveCode || data !== 8'h05) begin miscompares++; $display("FAIL ldi_c4_alu got %b/%0d/%h want 1/%0d/05", acc_we, aluOpe, data, moveCode); end vectors++;
      tick(1);
      if (dut.state_r !== S_FETCH || pc !== 8'h02) begin miscompares++; $display("FAIL ldi_c5 got %0d/%h want %0d/02", dut.state_r, pc, S_FETCH); end vectors++;
   endtask

   task automatic test_jmp;
      tick(3);
      if (acc_we !== 1'b0 || data !== 8'h00 || aluOpe !== moveCode) begin miscompares++; $display("FAIL jmp_exec got %b/%h/%0d want 0/00/%0d", acc_we, data, aluOpe, moveCode); end vectors++;
      tick(1);
      if (dut.state_r !== S_FETCH || pc !== 8'h10) begin miscompares++; $display("FAIL jmp_target got %0d/%h want %0d/10", dut.state_r, pc, S_FETCH); end vectors++;
   endtask

   task automatic test_jz;
      acc_zero = 1'b0;
      tick(4);
      if (dut.state_r !== S_FETCH || pc !== 8'h12) begin miscompares++; $display("FAIL jz_not_taken got %0d/%h want %0d/12", dut.state_r, pc, S_FETCH); end vectors++;
      tick(4);
      if (pc !== 8'h10) begin miscompares++; $display("FAIL jz_loop got %h want 10", pc); end vectors++;
      acc_zero = 1'b1;
      tick(4);
      acc_zero = 1'b0;
      if (dut.state_r !== S_FETCH || pc !== 8'h40) begin miscompares++; $display("FAIL jz_taken got %0d/%h want %0d/40", dut.state_r, pc, S_FETCH); end vectors++;
      tick(4);
      if (pc !== 8'h05) begin miscompares++; $display("FAIL jmp_05 got %h want 05", pc); end vectors++;
   endtask

   task automatic test_illegal;
      tick(1);
      if (dut.state_r !== S_DECODE || illegal !== 1'b0) begin miscompares++; $display("FAIL ill_decode got %0d/%b want %0d/0", dut.state_r, illegal, S_DECODE); end vectors++;
      tick(1);
      if (dut.state_r !== S_EXECUTE || illegal !== 1'b1 || acc_we !== 1'b0) begin miscompares++; $display("FAIL ill_exec got %0d/%b/%b want %0d/1/0", dut.state_r, illegal, acc_we, S_EXECUTE); end vectors++;
      tick(1);
      if (dut.state_r !== S_FETCH || pc !== 8'h06) begin miscompares++; $display("FAIL ill_next got %0d/%h want %0d/06", dut.state_r, pc, S_FETCH); end vectors++;
      tick(2);
      if (acc_we !== 1'b0 || illegal !== 1'b1) begin miscompares++; $display("FAIL nop_exec got %b/%b want 0/1", acc_we, illegal); end vectors++;
      tick(1);
      if (dut.state_r !== S_FETCH || pc !== 8'h07) begin miscompares++; $display("FAIL nop_next got %0d/%h want %0d/07", dut.state_r, pc, S_FETCH); end vectors++;
   endtask

   task automatic test_halt;
      tick(2);
      if (dut.state_r !== S_HALT || halted !== 1'b1 || pc !== 8'h08) begin miscompares++; $display("FAIL halt_enter got %0d/%b/%h want %0d/1/08", dut.state_r, halted, pc, S_HALT); end vectors++;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         if (halted !== 1'b1 || pc !== 8'h08 || acc_we !== 1'b0) begin miscompares++; $display("FAIL halt_hold%0d got %b/%h/%b want 1/08/0", i, halted, pc, acc_we); end vectors++;
      end
      start = 1'b1;
      tick(1);
      if (dut.state_r !== S_FETCH || pc !== 8'h08 || halted !== 1'b0) begin miscompares++; $display("FAIL halt_resume got %0d/%h/%b want %0d/08/0", dut.state_r, pc, halted, S_FETCH); end vectors++;
      tick(1);
      start = 1'b0;
      if (dut.state_r !== S_DECODE) begin miscompares++; $display("FAIL start_ignored got %0d want %0d", dut.state_r, S_DECODE); end vectors++;
      tick(3);
      if (dut.state_r !== S_FETCH || pc !== 8'hFF) begin miscompares++; $display("FAIL jmp_ff got %0d/%h want %0d/ff", dut.state_r, pc, S_FETCH); end vectors++;
   endtask

   task automatic test_wrap;
      tick(2);
      if (dut.state_r !== S_EXECUTE || pc !== 8'h00) begin miscompares++; $display("FAIL inc_exec got %0d/%h want %0d/00", dut.state_r, pc, S_EXECUTE); end vectors++;
      if (acc_we !== 1'b1 || aluOpe !== incrementCode || data !== 8'h00) begin miscompares++; $display("FAIL inc_alu got %b/%0d/%h want 1/%0d/00", acc_we, aluOpe, data, incrementCode); end vectors++;
      tick(1);
      if (dut.state_r !== S_FETCH || pc !== 8'h00) begin miscompares++; $display("FAIL inc_wrap got %0d/%h want %0d/00", dut.state_r, pc, S_FETCH); end vectors++;
   endtask

   task automatic test_reset_mid;
      mem[0] = 8'h2A;
      mem[1] = 8'h03;
      we_seen = 0;
      mon_en = 1'b1;
      tick(2);
      if (dut.state_r !== S_OPWAIT) begin miscompares++; $display("FAIL addi_opwait got %0d want %0d", dut.state_r, S_OPWAIT); end vectors++;
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      if (dut.state_r !== S_HALT || pc !== 8'h00 || halted !== 1'b1) begin miscompares++; $display("FAIL midrst_state got %0d/%h/%b want %0d/00/1", dut.state_r, pc, halted, S_HALT); end vectors++;
      if (illegal !== 1'b0) begin miscompares++; $display("FAIL midrst_illegal got %b want 0", illegal); end vectors++;
      tick(3);
      mon_en = 1'b0;
      if (we_seen !== 0) begin miscompares++; $display("FAIL midrst_we got %0d want 0", we_seen); end vectors++;
   endtask

   initial begin
      for (int a = 0; a < 256; a++) mem[a] = 8'h00;
      mem[8'h00] = 8'h10; mem[8'h01] = 8'h05;
      mem[8'h02] = 8'h90; mem[8'h03] = 8'h10;
      mem[8'h05] = 8'hC0; mem[8'h06] = 8'h00; mem[8'h07] = 8'hF0;
      mem[8'h08] = 8'h90; mem[8'h09] = 8'hFF;
      mem[8'h10] = 8'hA0; mem[8'h11] = 8'h40;
      mem[8'h12] = 8'h90; mem[8'h13] = 8'h10;
      mem[8'h40] = 8'h90; mem[8'h41] = 8'h05;
      mem[8'hFF] = 8'h70;
      rst = 1'b1; start = 1'b0; acc_zero = 1'b0;
      test_reset;
      test_ldi;
      test_jmp;
      test_jz;
      test_illegal;
      test_halt;
      test_wrap;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
